// File: rtl/dircc_rx_pkg.sv
// dircc_rx_pkg: shared state encoding and slot header layout for the rx message writer
package dircc_rx_pkg;
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RECV, DROP, HDR_LO, HDR_HI} state_t;
  localparam logic [14:0] HDR_LEN_OFS = 15'd0;
  localparam logic [14:0] HDR_FLAG_OFS = 15'd1;
  localparam logic [14:0] PAYLOAD_OFS = 15'd2;
  localparam int FLAG_VALID_BIT = 0;
  localparam int FLAG_TRUNC_BIT = 15;
  function automatic logic [15:0] hdr_flags(input logic trunc);
    logic [15:0] f = '0;
    f[FLAG_VALID_BIT] = 1'b1;
    f[FLAG_TRUNC_BIT] = trunc;
    return f;
  endfunction
endpackage

// File: rtl/dircc_node_rx_msg_writer_if.sv
// dircc_node_rx_msg_writer_if: Avalon-ST sink plus 16-bit s2 write port of the rx message writer
interface dircc_node_rx_msg_writer_if;
  logic [31:0] in_data;
  logic in_valid;
  logic in_ready;
  logic in_sop;
  logic in_eop;
  logic [14:0] mem_address;
  logic mem_chipselect;
  logic mem_write;
  logic [15:0] mem_writedata;
  logic [1:0] mem_byteenable;
  logic mem_clken;
  modport slave (
    input in_data, in_valid, in_sop, in_eop,
    output in_ready, mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken
  );
  modport master (
    output in_data, in_valid, in_sop, in_eop,
    input in_ready, mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken
  );
endinterface

// File: rtl/dircc_rx_slot_ring.sv
// dircc_rx_slot_ring: write-slot pointer, slot base address and occupancy of the slot ring
module dircc_rx_slot_ring #(
  parameter logic [14:0] BASE_ADDR = 15'h4000,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_HW = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        commit,
  input  logic        slot_release,
  output logic [14:0] slot_base,
  output logic [4:0]  slots_used,
  output logic        full,
  output logic        irq
);
  localparam int SW = $clog2(NUM_SLOTS);
  logic [SW-1:0] wr_slot;
  logic rel, wrap;
  assign rel = slot_release && slots_used != 5'd0;
  assign wrap = wr_slot == SW'(NUM_SLOTS - 1);
  assign full = slots_used == 5'(NUM_SLOTS);
  // base advances by addition so no multiplier sits on the address path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_slot <= '0;
      slot_base <= BASE_ADDR;
      slots_used <= 5'd0;
      irq <= 1'b0;
    end else begin
      if (commit) begin
        wr_slot <= wrap ? '0 : wr_slot + 1'b1;
        slot_base <= wrap ? BASE_ADDR : slot_base + 15'(SLOT_HW);
      end
      slots_used <= (commit && !rel) ? slots_used + 5'd1 :
                    (rel && !commit) ? slots_used - 5'd1 : slots_used;
      irq <= slots_used != 5'd0;
    end
  end
endmodule

// File: rtl/dircc_node_rx_msg_writer.sv
// dircc_node_rx_msg_writer: writes inbound Avalon-ST packets into a ring of fixed-size
// slots over the 16-bit s2 port; header (length, flags) is written last
module dircc_node_rx_msg_writer
  import dircc_rx_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h4000,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_HW = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  dircc_node_rx_msg_writer_if.slave   bus,
  input  logic                        slot_release,
  output logic [4:0]                  slots_used,
  output logic                        irq,
  output logic [7:0]                  err_cnt
);
  state_t state, state_d;
  logic [31:0] data_q;
  logic [14:0] hw_idx, slot_base;
  logic eop_q, trunc, run, full, commit, acc, start, drop_end, err_inc;
  dircc_rx_slot_ring #(.BASE_ADDR(BASE_ADDR), .NUM_SLOTS(NUM_SLOTS), .SLOT_HW(SLOT_HW)) u_ring (
    .clk, .reset_n, .commit, .slot_release, .slot_base, .slots_used, .full, .irq
  );
  // run holds in_ready low while reset is asserted even though state sits in IDLE
  assign bus.in_ready = run && ((state == IDLE && !full) || state == RECV || state == DROP);
  assign acc = bus.in_valid && bus.in_ready;
  assign start = acc && state == IDLE && bus.in_sop;
  assign drop_end = acc && state == DROP && bus.in_eop;
  assign err_inc = (acc && state == IDLE && !bus.in_sop) || drop_end;
  assign commit = state == HDR_HI;
  assign bus.mem_chipselect = bus.mem_write;
  assign bus.mem_byteenable = 2'b11;
  assign bus.mem_clken = 1'b1;
  always_comb begin
    state_d = state;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_writedata = '0;
    case (state)
      IDLE: state_d = start ? WR_LO : IDLE;
      WR_LO: begin
        bus.mem_write = 1'b1;
        bus.mem_address = slot_base + PAYLOAD_OFS + hw_idx;
        bus.mem_writedata = data_q[15:0];
        state_d = WR_HI;
      end
      WR_HI: begin
        bus.mem_write = 1'b1;
        bus.mem_address = slot_base + PAYLOAD_OFS + hw_idx;
        bus.mem_writedata = data_q[31:16];
        state_d = eop_q ? HDR_LO : (hw_idx + 15'd1 == 15'(SLOT_HW - 2)) ? DROP : RECV;
      end
      RECV: state_d = acc ? WR_LO : RECV;
      DROP: state_d = drop_end ? HDR_LO : DROP;
      HDR_LO: begin
        bus.mem_write = 1'b1;
        bus.mem_address = slot_base + HDR_LEN_OFS;
        bus.mem_writedata = {1'b0, hw_idx};
        state_d = HDR_HI;
      end
      HDR_HI: begin
        bus.mem_write = 1'b1;
        bus.mem_address = slot_base + HDR_FLAG_OFS;
        bus.mem_writedata = hdr_flags(trunc);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      run <= 1'b0;
      data_q <= '0;
      eop_q <= 1'b0;
      trunc <= 1'b0;
      hw_idx <= '0;
      err_cnt <= '0;
    end else begin
      run <= 1'b1;
      state <= state_d;
      if (start || (acc && state == RECV)) begin
        data_q <= bus.in_data;
        eop_q <= bus.in_eop;
      end
      if (start) hw_idx <= '0;
      else if (state == WR_LO || state == WR_HI) hw_idx <= hw_idx + 15'd1;
      if (start) trunc <= 1'b0;
      else if (drop_end) trunc <= 1'b1;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule
